// File: rtl/axis_bus_pkg.sv
// Shared constants, state encoding and select-code helper for the stream bus arbiter.
package axis_bus_pkg;

    localparam int unsigned N_PORTS_DEF   = 14;
    localparam int unsigned TIMEOUT_DEF   = 256;
    localparam int unsigned SEL_W         = 8;
    localparam int unsigned PKT_CNT_W     = 16;

    localparam logic [SEL_W-1:0] SEL_BASE_DEF    = 8'd128;
    localparam logic [SEL_W-1:0] NON_FIFO_CHOOSE = 8'd0;

    // Arbiter FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t XFER = 1'b1;

    // Mux select code for a port index; callers keep base+idx below 256
    function automatic logic [SEL_W-1:0] sel_code(input logic [SEL_W-1:0] base,
                                                  input logic [SEL_W-1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/axis_bus_arbiter_if.sv
// Arbiter-side view of the FIFO request lines, mux handshake and status outputs.
interface axis_bus_arbiter_if
    import axis_bus_pkg::*;
#(
    parameter int unsigned N_PORTS = N_PORTS_DEF
);

    logic [N_PORTS-1:0]   fifo_req;
    logic                 mux_tvalid;
    logic                 mux_tlast;
    logic                 out_tready;
    logic [SEL_W-1:0]     bus_sel;
    logic [N_PORTS-1:0]   fifo_tready;
    logic                 busy;
    logic                 timeout_err;
    logic [PKT_CNT_W-1:0] pkt_cnt;

    modport master (
        input  fifo_req,
        input  mux_tvalid,
        input  mux_tlast,
        input  out_tready,
        output bus_sel,
        output fifo_tready,
        output busy,
        output timeout_err,
        output pkt_cnt
    );

    modport slave (
        output fifo_req,
        output mux_tvalid,
        output mux_tlast,
        output out_tready,
        input  bus_sel,
        input  fifo_tready,
        input  busy,
        input  timeout_err,
        input  pkt_cnt
    );

endinterface

// File: rtl/axis_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester after 'last', wrapping.
module rr_pick #(
    parameter int unsigned N_PORTS = 14,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan from the farthest offset down so the nearest requester after 'last' wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = N_PORTS; i >= 1; i--) begin
            if (req[IDX_W'((32'(last) + i) % N_PORTS)]) begin
                idx   = IDX_W'((32'(last) + i) % N_PORTS);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_bus_arbiter.sv
// Packet-granular round-robin arbiter driving the select code of a FIFO-to-stream mux.
module axis_bus_arbiter
    import axis_bus_pkg::*;
#(
    parameter int unsigned      N_PORTS  = N_PORTS_DEF,
    parameter logic [SEL_W-1:0] SEL_BASE = SEL_BASE_DEF,
    parameter int unsigned      TIMEOUT  = TIMEOUT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    axis_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;
    logic                 armed_q;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 beat;
    logic [N_PORTS-1:0]   ready;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (bus.fifo_req),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign beat = (state_q == XFER) && bus.mux_tvalid && bus.out_tready;

    // Next state: grant from IDLE, end packet on tlast beat, abort on idle expiry
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d  = NON_FIFO_CHOOSE;
                busy_d = 1'b0;
                if (armed_q && pick_valid) begin
                    state_d = XFER;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    sel_d   = sel_code(SEL_BASE, SEL_W'(pick_idx));
                    busy_d  = 1'b1;
                end
            end
            XFER: begin
                if (beat) begin
                    cnt_d = '0;
                    if (bus.mux_tlast) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        pkt_d   = pkt_q + PKT_CNT_W'(1);
                        sel_d   = NON_FIFO_CHOOSE;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                    sel_d   = NON_FIFO_CHOOSE;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = NON_FIFO_CHOOSE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; armed_q blocks a grant on the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            pkt_q   <= '0;
            sel_q   <= NON_FIFO_CHOOSE;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            armed_q <= 1'b1;
        end
    end

    // Route downstream ready to the granted FIFO only
    always_comb begin
        ready = '0;
        if (state_q == XFER) begin
            ready[grant_q] = bus.out_tready;
        end
    end

    assign bus.fifo_tready = ready;
    assign bus.bus_sel     = sel_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_q;
    assign bus.pkt_cnt     = pkt_q;

endmodule

// File: doc/axis_bus_arbiter.md
AXIS_BUS_ARBITER -- requirements
Module: axis_bus_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 14, the number of FIFO input ports on the stream bus mux.
REQ-002 SHALL have parameter SEL_BASE, default 8'd128, the bus_sel code for port 0; port n is coded SEL_BASE+n.
REQ-003 SHALL have parameter TIMEOUT, default 256, the maximum number of cycles a granted port may go without a beat.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 fifo_req  input  N_PORTS  bit n high means FIFO n is non-empty and holds a packet.
REQ-007 mux_tvalid  input  1  axis_out_tvalid returned from the mux.
REQ-008 mux_tlast  input  1  axis_out_tlast returned from the mux.
REQ-009 out_tready  input  1  downstream ready for the mux output.
REQ-010 bus_sel  output  8  select code driven to the mux; 8'd0 means no FIFO is selected.
REQ-011 fifo_tready  output  N_PORTS  per-FIFO read ready.
REQ-012 busy  output  1  high while a packet transfer is granted.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant is aborted by timeout.
REQ-014 pkt_cnt  output  16  count of completed packets; wraps at 2^16.

Function
REQ-015 SHALL implement the states IDLE and XFER.
REQ-016 IDLE behaviour:
- bus_sel = 0, busy = 0, fifo_tready = 0.
- When any fifo_req bit is high, the arbiter SHALL grant the first requesting port after last_grant (round-robin, wrapping N_PORTS-1 to 0).
- The arbiter SHALL register the grant and go to XFER on the next edge.
REQ-017 From IDLE with no request, the first grant SHALL go to port 0, because the reset value of last_grant is N_PORTS-1.
REQ-018 XFER outputs SHALL be registered: bus_sel = SEL_BASE+grant and busy = 1.
REQ-019 fifo_tready SHALL be combinational: bit grant = out_tready while in XFER, and all other bits 0.
REQ-020 A beat SHALL be a cycle in XFER with mux_tvalid & out_tready.
REQ-021 A beat with mux_tlast set SHALL end the transfer:
- return to IDLE and set last_grant = grant;
- increment pkt_cnt (wrap 16'hFFFF to 0);
- bus_sel reads 0 on the next cycle.
REQ-022 The earliest re-grant after a tlast beat SHALL be two cycles later (IDLE lasts at least one cycle), including re-grant to the same port.
REQ-023 The grant SHALL NOT change mid-packet, regardless of fifo_req changes; deassertion of fifo_req for the granted port during XFER SHALL be ignored.
REQ-024 Idle counter rules:
- The counter clears on grant and on every beat, and increments in XFER on non-beat cycles.
- When it reaches TIMEOUT-1, the arbiter SHALL return to IDLE, pulse timeout_err for 1 cycle, set last_grant = grant, and leave pkt_cnt unchanged.
REQ-025 If a tlast beat and timeout expiry coincide, the tlast beat SHALL take precedence: pkt_cnt increments and timeout_err stays 0.
REQ-026 mux_tvalid and mux_tlast SHALL be ignored in IDLE.
REQ-027 Grant index SHALL be $clog2(N_PORTS) bits wide; the bus_sel sum SHALL be 8 bits with no overflow for N_PORTS <= 127.

Reset
REQ-028 Assertion of rst_n low SHALL asynchronously force:
- state IDLE, bus_sel 0, busy 0, timeout_err 0;
- pkt_cnt 0, idle counter 0, last_grant N_PORTS-1.
REQ-029 Reset asserted mid-packet SHALL abort the transfer immediately; fifo_tready SHALL be 0 during reset.
REQ-030 Deassertion of rst_n SHALL be synchronised by the integrating top; no grant SHALL occur in the first cycle after deassertion.

Structure
REQ-031 A shared package axis_bus_pkg SHALL hold:
- the SEL_BASE and NON_FIFO_CHOOSE (8'd0) constants;
- the default N_PORTS;
- the state encoding type (IDLE, XFER).
REQ-032 SHALL contain one sub-module, rr_pick: a combinational round-robin priority encoder with inputs req and last and output idx/valid.
REQ-033 The top SHALL contain the FSM, the idle counter, pkt_cnt and the ready routing; it SHALL NOT instantiate the mux.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset, then fifo_req=14'h0001 and a 3-beat packet with out_tready=1 -> bus_sel=8'd128 for 3 cycles, then 0, pkt_cnt=1.
- fifo_req=14'h3FFF steady, 1-beat packets -> grants in order 0,1,...,13,0; bus_sel 128..141 then 128; a 0 gap between each grant.
- Grant port 5, out_tready low for 10 cycles mid-packet -> bus_sel holds 8'd133, fifo_tready[5] follows out_tready, and fifo_tready is 0 on all other bits.
- Grant port 2 with mux_tvalid held 0 and TIMEOUT=16 -> timeout_err pulses on cycle 16 after grant, bus_sel returns to 0, pkt_cnt unchanged, next grant goes to port 3 when requesting.
- A tlast beat on the same cycle as timeout expiry -> pkt_cnt increments and timeout_err=0.
- rst_n pulsed low mid-packet on port 7 -> bus_sel=0 and busy=0 immediately (asynchronously); after release, a request on 7 and 0 -> grant to port 0.
